xrw_resp: RTL and testbench

XRW_RESP -- requirements
Module: xrw_resp

---
 rtl/xrw_resp.sv | 164 ++++++++++++++++
 tb/tb_xrw_resp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xrw_resp.sv
`default_nettype none
// ============================================================================
// Module   : xrw_resp
// Purpose  : Zero-wait-state register responder. Eight general registers,
//            a 4-entry FIFO with status, an optional free-running cycle
//            counter, sticky FIFO error flags and a registered interrupt.
// Config   : define XRW_RESP_CNT_EN to include the cycle counter at
//            address 10; without it address 10 reads 0 and ignores writes.
// Revision : 1.0 - initial release
// ============================================================================
module xrw_resp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rw_req,
    input  logic              rw_rnw,
    input  logic [ADDR_W-1:0] rw_addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] c_ADDR_FIFO   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] c_ADDR_CNT    = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] c_ADDR_ERR    = ADDR_W'(11);
    localparam logic [2:0]        c_FIFO_DEPTH  = 3'd4;

    logic [DATA_W-1:0] r_regs [0:7];
    logic [DATA_W-1:0] r_fifo [0:3];
    logic [1:0]        r_wptr;
    logic [1:0]        r_rptr;
    logic [2:0]        r_count;
    logic [1:0]        r_err;
    logic              r_irq;

    logic w_rd_en;
    logic w_wr_en;
    logic w_is_gpr;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_ovf;
    logic w_udf;
    logic [1:0] w_w1c;

    assign w_rd_en  = rw_req &  rw_rnw;
    assign w_wr_en  = rw_req & ~rw_rnw;
    assign w_is_gpr = (rw_addr < ADDR_W'(8));
    assign w_empty  = (r_count == 3'd0);
    assign w_full   = (r_count == c_FIFO_DEPTH);

    assign w_push    = w_wr_en && (rw_addr == c_ADDR_FIFO);
    assign w_pop     = w_rd_en && (rw_addr == c_ADDR_FIFO);
    assign w_push_ok = w_push && !w_full;
    assign w_pop_ok  = w_pop  && !w_empty;
    assign w_ovf     = w_push &&  w_full;
    assign w_udf     = w_pop  &&  w_empty;
    assign w_w1c     = (w_wr_en && (rw_addr == c_ADDR_ERR)) ? data_to_wr[1:0] : 2'b00;

`ifdef XRW_RESP_CNT_EN
    logic [DATA_W-1:0] r_cnt;
    logic              w_cnt_clr;

    assign w_cnt_clr = w_wr_en && (rw_addr == c_ADDR_CNT);

    // Free-running cycle counter; a write in the same cycle forces 0 instead of incrementing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DATA_W'(1);
        end
    end
`endif

    // General-purpose register file writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en && w_is_gpr) begin
            r_regs[rw_addr[2:0]] <= data_to_wr;
        end
    end

    // FIFO storage; contents are don't-care after reset since pointers restart at 0
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst) begin
            r_fifo[r_wptr] <= data_to_wr;
        end
    end

    // FIFO pointers and occupancy; rejected push/pop leaves them untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 2'd1;
            end
            if (w_push_ok) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop_ok) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    // Sticky error flags: W1C clears first, then new events set, so a set always wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 2'b00;
        end else begin
            r_err <= (r_err & ~w_w1c) | {w_udf, w_ovf};
        end
    end

    // Interrupt follows the error register with one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_err;
        end
    end

    assign irq = r_irq;

    // Combinational read mux; idle and write cycles return 0
    always_comb begin
        data_to_rd = '0;
        if (w_rd_en) begin
            if (w_is_gpr) begin
                data_to_rd = r_regs[rw_addr[2:0]];
            end else begin
                case (rw_addr)
                    c_ADDR_FIFO:   data_to_rd = w_empty ? '0 : r_fifo[r_rptr];
                    c_ADDR_STATUS: data_to_rd = {{(DATA_W-5){1'b0}}, r_count, w_full, w_empty};
`ifdef XRW_RESP_CNT_EN
                    c_ADDR_CNT:    data_to_rd = r_cnt;
`endif
                    c_ADDR_ERR:    data_to_rd = {{(DATA_W-2){1'b0}}, r_err};
                    default:       data_to_rd = '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xrw_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_xrw_resp
// Purpose  : Self-checking bench for xrw_resp: directed scenarios followed by
//            randomized traffic, all compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xrw_resp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              rw_req;
    logic              rw_rnw;
    logic [ADDR_W-1:0] rw_addr;
    logic [DATA_W-1:0] data_to_wr;
    logic [DATA_W-1:0] data_to_rd;
    logic              irq;

    xrw_resp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rw_req     (rw_req),
        .rw_rnw     (rw_rnw),
        .rw_addr    (rw_addr),
        .data_to_wr (data_to_wr),
        .data_to_rd (data_to_rd),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [31:0] m_regs [8];
    logic [31:0] m_fifo [$];
    logic [1:0]  m_err;
    logic        m_irq;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic req, input logic rnw, input logic [3:0] addr);
        int n;
        n = m_fifo.size();
        if (!req || !rnw) return 32'd0;
        if (addr < 4'd8) return m_regs[addr[2:0]];
        case (addr)
            4'd8:  return (n == 0) ? 32'd0 : m_fifo[0];
            4'd9:  return (32'(n) << 2) | ((n == 4) ? 32'd2 : 32'd0) | ((n == 0) ? 32'd1 : 32'd0);
`ifdef XRW_RESP_CNT_EN
            4'd10: return m_cnt;
`endif
            4'd11: return {30'd0, m_err};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_fifo.delete();
        m_err = 2'b00;
        m_irq = 1'b0;
        m_cnt = 32'd0;
    endtask

    task automatic model_step(input logic req, input logic rnw, input logic [3:0] addr, input logic [31:0] wd);
        logic [1:0] ev;
        logic [1:0] clr;
        logic       cnt_clr;
        ev = 2'b00;
        clr = 2'b00;
        cnt_clr = 1'b0;
        m_irq = |m_err;
        if (req && !rnw) begin
            if (addr < 4'd8) m_regs[addr[2:0]] = wd;
            if (addr == 4'd8) begin
                if (m_fifo.size() == 4) ev[0] = 1'b1;
                else m_fifo.push_back(wd);
            end
            if (addr == 4'd10) cnt_clr = 1'b1;
            if (addr == 4'd11) clr = wd[1:0];
        end
        if (req && rnw && addr == 4'd8) begin
            if (m_fifo.size() == 0) ev[1] = 1'b1;
            else void'(m_fifo.pop_front());
        end
        m_err = (m_err & ~clr) | ev;
        m_cnt = cnt_clr ? 32'd0 : m_cnt + 32'd1;
    endtask

    // One bus cycle: drive at negedge, check read data before the edge, check irq after
    task automatic cycle(input logic req, input logic rnw, input logic [3:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk);
        rw_req = req; rw_rnw = rnw; rw_addr = addr; data_to_wr = wd;
        #1;
        rd = data_to_rd;
        chk($sformatf("rd a%0d", addr), data_to_rd, model_read(req, rnw, addr));
        @(posedge clk);
        model_step(req, rnw, addr, wd);
        #1;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        cycle(1'b1, 1'b0, addr, wd, rd);
    endtask

    task automatic rd_(input logic [3:0] addr, output logic [31:0] rd);
        cycle(1'b1, 1'b1, addr, 32'd0, rd);
    endtask

    task automatic idle();
        logic [31:0] rd;
        cycle(1'b0, 1'b0, 4'd0, 32'd0, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [31:0] exp_pop [$];

        rst = 1'b1; rw_req = 1'b0; rw_rnw = 1'b0; rw_addr = '0; data_to_wr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset irq", {31'd0, irq}, 32'd0);
        rw_req = 1'b1; rw_rnw = 1'b1; rw_addr = 4'd9;
        #1;
        chk("reset status", data_to_rd, 32'h1);
        @(negedge clk);
        rst = 1'b0; rw_req = 1'b0;

        // Register write/read
        wr(4'd3, 32'h0000_00A5);
        rd_(4'd3, rd); chk("r3", rd, 32'h0000_00A5);
        rd_(4'd4, rd); chk("r4", rd, 32'd0);

        // FIFO fill, overflow, drain
        wr(4'd8, 32'h11); wr(4'd8, 32'h22); wr(4'd8, 32'h33); wr(4'd8, 32'h44);
        wr(4'd8, 32'h55);
        rd_(4'd9, rd);  chk("status full", rd, 32'h12);
        chk("irq after ovf", {31'd0, irq}, 32'd1);
        rd_(4'd11, rd); chk("err ovf", rd, 32'h1);
        rd_(4'd8, rd);  chk("pop0", rd, 32'h11);
        rd_(4'd8, rd);  chk("pop1", rd, 32'h22);
        rd_(4'd8, rd);  chk("pop2", rd, 32'h33);
        rd_(4'd8, rd);  chk("pop3", rd, 32'h44);
        wr(4'd11, 32'h3);
        idle();

        // Underflow and W1C
        rd_(4'd8, rd);  chk("pop empty", rd, 32'd0);
        rd_(4'd11, rd); chk("err udf", rd, 32'h2);
        wr(4'd11, 32'h2);
        rd_(4'd11, rd); chk("err cleared", rd, 32'd0);
        chk("irq cleared", {31'd0, irq}, 32'd0);

        // Interleaved push/pop across pointer wrap
        wr(4'd8, 32'hA1); wr(4'd8, 32'hA2); wr(4'd8, 32'hA3);
        rd_(4'd8, rd); chk("il pop a1", rd, 32'hA1);
        wr(4'd8, 32'hA4);
        rd_(4'd8, rd); chk("il pop a2", rd, 32'hA2);
        wr(4'd8, 32'hA5);
        rd_(4'd9, rd); chk("il status3", rd, 32'hC);
        wr(4'd8, 32'hA6);
        rd_(4'd9, rd); chk("il status4", rd, 32'h12);
        rd_(4'd8, rd); chk("il pop a3", rd, 32'hA3);
        rd_(4'd8, rd); chk("il pop a4", rd, 32'hA4);
        rd_(4'd8, rd); chk("il pop a5", rd, 32'hA5);
        rd_(4'd8, rd); chk("il pop a6", rd, 32'hA6);
        rd_(4'd11, rd); chk("il no err", rd, 32'd0);

        // Cycle counter
        rd_(4'd10, c0);
        repeat (4) idle();
        rd_(4'd10, c1);
`ifdef XRW_RESP_CNT_EN
        chk("cnt delta", c1 - c0, 32'd5);
`else
        chk("cnt absent0", c0, 32'd0);
        chk("cnt absent1", c1, 32'd0);
`endif
        wr(4'd10, 32'hFFFF_FFFF);
        idle();
        rd_(4'd10, rd);
`ifdef XRW_RESP_CNT_EN
        chk("cnt after clr", rd, 32'd1);
`else
        chk("cnt absent2", rd, 32'd0);
`endif

        // Reset mid-stream with FIFO count 3 and R0 set
        rd_(4'd8, rd);
        wr(4'd0, 32'hFF);
        wr(4'd8, 32'h1); wr(4'd8, 32'h2); wr(4'd8, 32'h3);
        rd_(4'd9, rd); chk("pre-rst status", rd, 32'hC);
        chk("pre-rst irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b1; rw_req = 1'b1; rw_rnw = 1'b1; rw_addr = 4'd0;
        #1;
        chk("rst irq imm", {31'd0, irq}, 32'd0);
        chk("rst r0 imm", data_to_rd, 32'd0);
        rw_addr = 4'd9;
        #1;
        chk("rst status imm", data_to_rd, 32'h1);
        rw_rnw = 1'b0; rw_addr = 4'd8; data_to_wr = 32'hDEAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rw_req = 1'b0;
        model_reset();
        rd_(4'd9, rd);  chk("post-rst status", rd, 32'h1);
        rd_(4'd0, rd);  chk("post-rst r0", rd, 32'd0);
        rd_(4'd11, rd); chk("post-rst err", rd, 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic       req;
            logic       rnw;
            logic [3:0] addr;
            logic [31:0] wd;
            req  = ($urandom_range(0, 9) != 0);
            rnw  = $urandom_range(0, 1) == 1;
            addr = ($urandom_range(0, 1) == 1) ? 4'(8 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            wd   = $urandom;
            if (addr == 4'd11 && $urandom_range(0, 3) != 0) wd = 32'd0;
            cycle(req, rnw, addr, wd, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
